// File: rtl/laser_controller.sv
// laser_controller: sequences the single player laser (launch, per-frame
// advance, termination on hit or screen bottom, cooldown) and produces a
// registered laser pixel colour code for the display colour mux.
// Optional feature: define LASER_AUTOFIRE_EN to fire on the fire level
// instead of on its rising edge.
module laser_controller #(
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int V_OFFSET        = 10,
  parameter int SHIP_HEIGHT     = 30,
  parameter int LASER_WIDTH     = 4,
  parameter int LASER_HEIGHT    = 12,
  parameter int LASER_STEP      = 8,
  parameter int COOLDOWN_FRAMES = 15,
  parameter logic [2:0] LASER   = 3'd6,
  parameter logic [2:0] NONE    = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic       frameTick,
  input  logic [9:0] gunPosition,
  input  logic       hit,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic [9:0] laserX,
  output logic [9:0] laserY,
  output logic       laserActive,
  output logic       fired,
  output logic [2:0] color
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  localparam logic [9:0]  LAUNCH_Y   = 10'(V_OFFSET + SHIP_HEIGHT);
  localparam logic [9:0]  STEP       = 10'(LASER_STEP);
  localparam logic [10:0] HALF_W     = 11'(LASER_WIDTH / 2);
  localparam logic [10:0] HEIGHT_EXT = 11'(LASER_HEIGHT);
  localparam logic [10:0] REACH      = 11'(LASER_STEP + LASER_HEIGHT);
  localparam logic [10:0] BOTTOM     = 11'(SCREEN_HEIGHT);
  localparam logic [9:0]  CENTRE_X   = 10'(SCREEN_WIDTH / 2);
  localparam logic [7:0]  COOL_INIT  = 8'(COOLDOWN_FRAMES);

  state_t     state_q, state_d;
  logic [9:0] laser_x_q, laser_x_d;
  logic [9:0] laser_y_q, laser_y_d;
  logic [7:0] count_q, count_d;
  logic       fired_q, fired_d;
  logic [2:0] color_q, color_d;
  logic       request;
  logic       expire;

`ifdef LASER_AUTOFIRE_EN
  assign request = fire;
`else
  logic fire_q;

  // Remember last cycle's fire level so only a fresh press launches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fire_q <= 1'b0;
    else       fire_q <= fire;
  end

  assign request = fire & ~fire_q;
`endif

  // 11-bit sum so the bottom-of-screen test never wraps
  assign expire = ({1'b0, laser_y_q} + REACH) >= BOTTOM;

  // State and laser registers, all cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      laser_x_q <= CENTRE_X;
      laser_y_q <= '0;
      count_q   <= '0;
      fired_q   <= 1'b0;
      color_q   <= NONE;
    end else begin
      state_q   <= state_d;
      laser_x_q <= laser_x_d;
      laser_y_q <= laser_y_d;
      count_q   <= count_d;
      fired_q   <= fired_d;
      color_q   <= color_d;
    end
  end

  // Next-state logic: launch, advance with hit > expire > advance, cooldown
  always_comb begin
    state_d   = state_q;
    laser_x_d = laser_x_q;
    laser_y_d = laser_y_q;
    count_d   = count_q;
    fired_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          laser_x_d = gunPosition;
          laser_y_d = LAUNCH_Y;
          state_d   = FLYING;
          fired_d   = 1'b1;
        end
      end
      FLYING: begin
        if (hit || (frameTick && expire)) begin
          state_d = COOLDOWN;
          count_d = COOL_INIT;
        end else if (frameTick) begin
          laser_y_d = laser_y_q + STEP;
        end
      end
      COOLDOWN: begin
        if (count_q == 8'd0) begin
          state_d = IDLE;
        end else if (frameTick) begin
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic [10:0] x_ext, y_ext, h_ext, v_ext;
  logic [10:0] left_edge, right_edge, bottom_edge;

  // Pixel hit test against the laser box, left edge clamped at zero
  always_comb begin
    x_ext       = {1'b0, laser_x_q};
    y_ext       = {1'b0, laser_y_q};
    h_ext       = {1'b0, hPos};
    v_ext       = {1'b0, vPos};
    left_edge   = (x_ext < HALF_W) ? 11'd0 : (x_ext - HALF_W);
    right_edge  = x_ext + HALF_W;
    bottom_edge = y_ext + HEIGHT_EXT;
    color_d     = NONE;
    if ((state_q == FLYING) &&
        (h_ext >= left_edge) && (h_ext < right_edge) &&
        (v_ext >= y_ext) && (v_ext < bottom_edge)) begin
      color_d = LASER;
    end
  end

  assign laserX      = laser_x_q;
  assign laserY      = laser_y_q;
  assign laserActive = (state_q == FLYING);
  assign fired       = fired_q;
  assign color       = color_q;

endmodule
